// File: rtl/bcd_step_source_if.sv
// Digit-source control/status bundle: stepping controls in,
// BCD digit lines plus status pulses out.
interface bcd_step_source_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       valid;
  logic       carry;
  logic       err_load;

  modport master (
    output en, up, load, load_val,
    input  a, b, c, d, valid, carry, err_load
  );

  modport slave (
    input  en, up, load, load_val,
    output a, b, c, d, valid, carry, err_load
  );
endinterface

// File: rtl/bcd_step_source.sv
// Prescaled up/down BCD digit source with parallel load,
// wrap carry and rejected-load flag; all outputs registered.
module bcd_step_source #(
  parameter int PRESCALE = 4,
  parameter int PW       = 16
) (
  input logic clk,
  input logic rst_n,
  bcd_step_source_if.slave io
);

  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] p_q, p_d;
  logic [3:0]    dig_q, dig_d;
  logic          valid_q, valid_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;

  logic step;
  logic load_ok;
  logic load_bad;

  assign step     = io.en && (p_q == PMAX);
  assign load_ok  = io.load && (io.load_val <= 4'd9);
  assign load_bad = io.load && (io.load_val > 4'd9);

  always_comb begin
    p_d     = p_q;
    dig_d   = dig_q;
    valid_d = valid_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (io.en) begin
      p_d = step ? '0 : p_q + PW'(1);
    end
    // A good load wins outright; a bad one lets the step through.
    if (load_ok) begin
      dig_d   = io.load_val;
      p_d     = '0;
      valid_d = 1'b1;
    end else begin
      err_d = load_bad;
      if (step) begin
        valid_d = 1'b1;
        if (io.up) begin
          carry_d = (dig_q == 4'd9);
          dig_d   = (dig_q == 4'd9) ? 4'd0 : dig_q + 4'd1;
        end else begin
          carry_d = (dig_q == 4'd0);
          dig_d   = (dig_q == 4'd0) ? 4'd9 : dig_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      dig_q   <= 4'd0;
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      p_q     <= p_d;
      dig_q   <= dig_d;
      valid_q <= valid_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign {io.a, io.b, io.c, io.d} = dig_q;
  assign io.valid    = valid_q;
  assign io.carry    = carry_q;
  assign io.err_load = err_q;

endmodule

// File: doc/bcd_step_source.md
Name: bcd_step_source

Overview:
- Upstream stimulus stage for the 4-bit code converter.
- Generates a registered BCD digit (0..9) on four single-bit lines a,b,c,d (a = MSB, d = LSB), ready to wire directly to the converter's a..d inputs.
- Steps the digit up or down at a programmable rate derived from the system clock, with parallel load, wrap carry and a load-error flag.
- Replaces free-running toggles with a controlled, synthesizable digit source.

Parameters:
- PRESCALE, 4, clock cycles per digit step (legal range 1..65535).
- PW, 16, prescaler counter width (must hold PRESCALE-1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; prescaler and stepping advance only while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel-load request.
- load_val  input  4  value to load; must be 0..9.
- a  output  1  digit bit 3 (MSB).
- b  output  1  digit bit 2.
- c  output  1  digit bit 1.
- d  output  1  digit bit 0 (LSB).
- valid  output  1  digit holds a defined value.
- carry  output  1  one-cycle pulse on wrap.
- err_load  output  1  one-cycle pulse on rejected load.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces digit=0 (a=b=c=d=0), prescaler=0, valid=0, carry=0, err_load=0.
  - Reset mid-count discards all state; counting resumes from 0 after release.
- Prescaler:
  - Counter p runs 0..PRESCALE-1 while en=1; holds its value while en=0.
  - step is internal and combinational: en=1 and p==PRESCALE-1. On step, p wraps to 0 on the same edge.
  - PRESCALE=1 means step on every enabled cycle.
  - Changing up mid-interval does not reset p.
- Stepping (on the clock edge where step=1 and load=0):
  - up=1: digit+1; 9 wraps to 0 and asserts carry for exactly that next cycle.
  - up=0: digit-1; 0 wraps to 9 and asserts carry.
  - valid goes to 1 and stays 1 until reset.
  - Digit is never outside 0..9.
- Load (priority over step):
  - load=1 and load_val<=9: digit<=load_val, p<=0, valid<=1. No carry, even if a step coincides; the coincident step is dropped.
  - load=1 and load_val>=10: digit, p and valid are unchanged; err_load pulses high for one cycle. A coincident step still proceeds normally.
  - load held high for several cycles reloads every cycle and keeps p at 0, so no steps occur.
- Latency and outputs:
  - All outputs are registered.
  - Digit, carry and err_load change on the clock edge that evaluates step/load; visible one cycle after the triggering condition is sampled.
  - carry and err_load are never high for two consecutive cycles unless re-triggered.

Test Plan:
- Reset, then en=1, up=1, PRESCALE=4 -> digit 0,1,2,... changes every 4 clocks; valid rises with the first step; abcd=1001 after 36 clocks.
- Continue up from 9 -> next step gives abcd=0000 with carry=1 for one cycle only; no carry on 0->1.
- up=0 starting at 0 -> next step gives 9 with carry pulse; then 8, 7 at 4-clock spacing; flipping up mid-interval does not shorten that interval.
- load=1, load_val=7 coinciding with a step -> abcd=0111, carry=0, next step arrives 4 clocks later; load_val=12 -> digit unchanged, err_load one-cycle pulse, valid unchanged.
- en=0 for 10 cycles at p=2 -> digit and p frozen; resume en=1 -> next step after 2 more clocks.
- Assert rst_n=0 mid-interval while digit=5 -> outputs go 0 immediately without a clock edge, valid=0; after release, first step after PRESCALE enabled clocks yields 1.
